// File: rtl/mul_pkg.sv
// Shared types for the Booth multiplier: radix-16 digit selects, sequencer states
// and window-count helper.
package mul_pkg;

    localparam int unsigned BOOTH_WIN_BITS = 5;
    localparam int unsigned BOOTH_GUARD    = 4;

    typedef enum logic [3:0] {
        PP_0  = 4'd0,
        PP_A  = 4'd1,
        PP_2A = 4'd2,
        PP_3A = 4'd3,
        PP_4A = 4'd4,
        PP_5A = 4'd5,
        PP_6A = 4'd6,
        PP_7A = 4'd7,
        PP_8A = 4'd8
    } booth_sel_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRECOMP = 2'd1,
        EMIT    = 2'd2
    } seq_state_t;

    function automatic int unsigned booth_nwin(input int unsigned width);
        return width / 4;
    endfunction

endpackage

// File: rtl/booth_encoder.sv
// Radix-16 Booth digit encoder: 5-bit window {b3,b2,b1,b0,b_prev} -> |digit| select
// and sign. The all-ones window encodes zero with the sign bit still set.
module booth_encoder
    import mul_pkg::*;
(
    input  logic [BOOTH_WIN_BITS-1:0] win,
    output booth_sel_t                sel_c,
    output logic                      neg_c
);

    logic [3:0] sum;
    logic [3:0] mag;

    // digit = -8*w4 + 4*w3 + 2*w2 + w1 + w0; magnitude 0..8
    always_comb begin
        sum   = 4'(win[3:1]) + 4'(win[0]);
        mag   = win[4] ? 4'(4'd8 - sum) : sum;
        neg_c = win[4];
        sel_c = PP_0;
        case (mag)
            4'd1:    sel_c = PP_A;
            4'd2:    sel_c = PP_2A;
            4'd3:    sel_c = PP_3A;
            4'd4:    sel_c = PP_4A;
            4'd5:    sel_c = PP_5A;
            4'd6:    sel_c = PP_6A;
            4'd7:    sel_c = PP_7A;
            4'd8:    sel_c = PP_8A;
            default: sel_c = PP_0;
        endcase
    end

endmodule

// File: rtl/booth_pp_sequencer.sv
// Sequential radix-16 Booth partial-product source: latches A/B, precomputes the
// multiples of A, then streams one (possibly inverted) PP per 4-bit window of B.
// Optional BOOTH_SKIP_ZERO_EN drops zero-digit windows except the final one.
module booth_pp_sequencer
    import mul_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned NWIN  = booth_nwin(WIDTH),
    localparam int unsigned IW    = (NWIN > 1) ? $clog2(NWIN) : 1,
    localparam int unsigned PW    = WIDTH + BOOTH_GUARD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             pp_valid,
    input  logic             pp_ready,
    output logic [PW-1:0]    pp_out,
    output logic             pp_neg,
    output logic [IW-1:0]    pp_idx,
    output logic             pp_last
);

    seq_state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    cnt_q, cnt_d;

    logic [PW-1:0] mult_q [1:8];
    logic [PW-1:0] mult_d [1:8];
    logic [PW-1:0] mult_c [1:8];
    logic [PW-1:0] msrc   [1:8];

    logic          pp_valid_d;
    logic [PW-1:0] pp_out_d;
    logic          pp_neg_d;
    logic [IW-1:0] pp_idx_d;
    logic          pp_last_d;

    logic [BOOTH_WIN_BITS-1:0] win_c;
    booth_sel_t                sel_c;
    logic                      neg_c;
    logic [PW-1:0]             mult_sel_c;
    logic [PW-1:0]             pp_data_c;
    logic                      last_win_c;
    logic                      skip_c;
    logic                      eval;
    logic [PW-1:0]             a_x;

    assign in_ready = (state_q == IDLE) && !rst;

    // Window i = {B[4i+3:4i], B[4i-1]} with an implicit zero below bit 0
    assign win_c      = BOOTH_WIN_BITS'({b_q, 1'b0} >> {cnt_q, 2'b00});
    assign last_win_c = (cnt_q == IW'(NWIN - 1));

    booth_encoder u_enc (
        .win   (win_c),
        .sel_c (sel_c),
        .neg_c (neg_c)
    );

    // Four guard bits make every multiple up to 8A exact for any signed A
    assign a_x = {{BOOTH_GUARD{a_q[WIDTH-1]}}, a_q};

    always_comb begin
        mult_c[1] = a_x;
        mult_c[2] = a_x << 1;
        mult_c[3] = (a_x << 1) + a_x;
        mult_c[4] = a_x << 2;
        mult_c[5] = (a_x << 2) + a_x;
        mult_c[6] = ((a_x << 1) + a_x) << 1;
        mult_c[7] = (a_x << 3) - a_x;
        mult_c[8] = a_x << 3;
    end

    // Window 0 is selected while the multiples are still being registered
    always_comb begin
        for (int k = 1; k <= 8; k++) begin
            msrc[k] = (state_q == PRECOMP) ? mult_c[k] : mult_q[k];
        end
    end

    always_comb begin
        mult_sel_c = '0;
        case (sel_c)
            PP_A:    mult_sel_c = msrc[1];
            PP_2A:   mult_sel_c = msrc[2];
            PP_3A:   mult_sel_c = msrc[3];
            PP_4A:   mult_sel_c = msrc[4];
            PP_5A:   mult_sel_c = msrc[5];
            PP_6A:   mult_sel_c = msrc[6];
            PP_7A:   mult_sel_c = msrc[7];
            PP_8A:   mult_sel_c = msrc[8];
            default: mult_sel_c = '0;
        endcase
    end

    assign pp_data_c = neg_c ? ~mult_sel_c : mult_sel_c;

`ifdef BOOTH_SKIP_ZERO_EN
    assign skip_c = (sel_c == PP_0) && !last_win_c;
`else
    assign skip_c = 1'b0;
`endif

    // State, operand, multiple and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            for (int k = 1; k <= 8; k++) begin
                mult_q[k] <= '0;
            end
            pp_valid <= 1'b0;
            pp_out   <= '0;
            pp_neg   <= 1'b0;
            pp_idx   <= '0;
            pp_last  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            mult_q   <= mult_d;
            pp_valid <= pp_valid_d;
            pp_out   <= pp_out_d;
            pp_neg   <= pp_neg_d;
            pp_idx   <= pp_idx_d;
            pp_last  <= pp_last_d;
        end
    end

    // Next-state and output-register loading
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        mult_d     = mult_q;
        pp_valid_d = pp_valid;
        pp_out_d   = pp_out;
        pp_neg_d   = pp_neg;
        pp_idx_d   = pp_idx;
        pp_last_d  = pp_last;
        eval       = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    cnt_d   = '0;
                    state_d = PRECOMP;
                end
            end
            PRECOMP: begin
                mult_d  = mult_c;
                state_d = EMIT;
                eval    = 1'b1;
            end
            EMIT: begin
                if (pp_valid && pp_ready && pp_last) begin
                    state_d    = IDLE;
                    pp_valid_d = 1'b0;
                    pp_last_d  = 1'b0;
                end else if (!pp_valid || pp_ready) begin
                    eval = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Either step past a zero window or present the current window
        if (eval) begin
            cnt_d = cnt_q + IW'(1);
            if (skip_c) begin
                pp_valid_d = 1'b0;
            end else begin
                pp_valid_d = 1'b1;
                pp_out_d   = pp_data_c;
                pp_neg_d   = neg_c;
                pp_idx_d   = cnt_q;
                pp_last_d  = last_win_c;
            end
        end
    end

endmodule

// File: tb/tb_booth_pp_sequencer.sv
// Directed + random bench for booth_pp_sequencer (WIDTH=16) with an arithmetic
// reference model feeding an expected-PP queue; honours BOOTH_SKIP_ZERO_EN.
module tb_booth_pp_sequencer;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NWIN  = 4;
    localparam int unsigned IW    = 2;
    localparam int unsigned PW    = WIDTH + 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             pp_valid;
    logic             pp_ready;
    logic [PW-1:0]    pp_out;
    logic             pp_neg;
    logic [IW-1:0]    pp_idx;
    logic             pp_last;

    typedef struct packed {
        logic [PW-1:0] data;
        logic          neg;
        logic [IW-1:0] idx;
        logic          last;
    } pp_exp_t;

    pp_exp_t exp_q[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    booth_pp_sequencer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .pp_valid (pp_valid),
        .pp_ready (pp_ready),
        .pp_out   (pp_out),
        .pp_neg   (pp_neg),
        .pp_idx   (pp_idx),
        .pp_last  (pp_last)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: digit value from the window arithmetic, PP = |d|*A, inverted when negative
    task automatic push_model(input logic signed [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              output int first_wait, output logic [31:0] prod);
        logic [WIDTH:0] bx;
        bit seen;
        bx = {b, 1'b0};
        seen = 0;
        first_wait = 0;
        prod = 32'(int'(a) * int'($signed(b)));
        for (int i = 0; i < int'(NWIN); i++) begin
            logic [4:0] w;
            int d;
            int mag;
            logic [PW-1:0] m;
            pp_exp_t e;
            w   = bx[4*i +: 5];
            d   = 4*int'(w[3]) + 2*int'(w[2]) + int'(w[1]) + int'(w[0]) - (w[4] ? 8 : 0);
            mag = (d < 0) ? -d : d;
            m   = PW'(mag * int'(a));
            e.neg  = (d < 0) || (w == 5'b11111);
            e.data = e.neg ? ~m : m;
            e.idx  = IW'(i);
            e.last = (i == int'(NWIN) - 1);
`ifdef BOOTH_SKIP_ZERO_EN
            if (mag == 0 && i < int'(NWIN) - 1) begin
                if (!seen) first_wait++;
                continue;
            end
`endif
            seen = 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output int first_wait, output logic [31:0] prod);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        push_model(a, b, first_wait, prod);
        @(negedge clk);
        in_valid = 1'b0;
        check("precomp_in_ready", 64'(in_ready), 64'd0);
        check("precomp_pp_valid", 64'(pp_valid), 64'd0);
    endtask

    task automatic drain(input int exp_wait, input int stall_idx, input int stall_len,
                         input logic [31:0] exp_prod);
        int wait_n, cyc, slen;
        bit done, first;
        longint acc;
        pp_exp_t e, held;
        logic signed [PW-1:0] s;
        wait_n = 0; cyc = 0; done = 0; first = 1; acc = 0; slen = stall_len;
        pp_ready = 1'b1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!pp_valid) begin
                if (first) wait_n++;
                continue;
            end
            if (first) begin
                check("first_pp_latency", 64'(wait_n), 64'(exp_wait));
                first = 0;
            end
            if (slen > 0 && int'(pp_idx) == stall_idx) begin
                held = {pp_out, pp_neg, pp_idx, pp_last};
                pp_ready = 1'b0;
                repeat (slen) begin
                    @(negedge clk);
                    check("stall_valid", 64'(pp_valid), 64'd1);
                    check("stall_hold", 64'({pp_out, pp_neg, pp_idx, pp_last}), 64'(held));
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                end
                pp_ready = 1'b1;
                slen = 0;
            end
            if (exp_q.size() == 0) begin
                check("unexpected_pp", 64'd1, 64'd0);
                done = 1;
            end else begin
                e = exp_q.pop_front();
                check("pp_fields", 64'({pp_out, pp_neg, pp_idx, pp_last}), 64'(e));
                s = pp_out;
                acc = acc + ((longint'(s) + longint'(pp_neg)) <<< (4 * int'(pp_idx)));
                if (pp_last) done = 1;
            end
        end
        check("drain_timeout", 64'(done), 64'd1);
        check("product", 64'(acc[31:0]), 64'(exp_prod));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check("post_last_in_ready", 64'(in_ready), 64'd1);
        check("post_last_pp_valid", 64'(pp_valid), 64'd0);
    endtask

    initial begin
        int fw;
        int n;
        logic [31:0] prod;
        rst = 1'b1;
        in_valid = 1'b0;
        pp_ready = 1'b0;
        a_in = '0;
        b_in = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_pp_valid", 64'(pp_valid), 64'd0);
        check("rst_pp_fields", 64'({pp_out, pp_neg, pp_idx, pp_last}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // A=3, B=7
        send(16'd3, 16'd7, fw, prod);
        check("model_3x7", 64'(prod), 64'd21);
        drain(fw, -1, 0, prod);

        // A=3, B=-1
        send(16'd3, 16'hFFFF, fw, prod);
        drain(fw, -1, 0, prod);

        // Most negative operands: PP_8A of -32768
        send(16'h8000, 16'h8000, fw, prod);
        check("model_min_min", 64'(prod), 64'h4000_0000);
        drain(fw, -1, 0, prod);

        // Backpressure on idx1 for 5 cycles
        send(16'hFB2E, 16'h5A3C, fw, prod);
        drain(fw, 1, 5, prod);

        // Reset while idx2 is presented
        send(16'd1234, 16'hEF1F, fw, prod);
        pp_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(pp_valid && pp_idx == 2'd2) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reached_idx2", 64'(pp_valid && pp_idx == 2'd2), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_pp_valid", 64'(pp_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_pp_fields", 64'({pp_out, pp_neg, pp_idx, pp_last}), 64'd0);
        @(negedge clk);
        check("abort_quiet", 64'(pp_valid), 64'd0);
        send(16'd5, 16'd2, fw, prod);
        drain(fw, -1, 0, prod);

`ifdef BOOTH_SKIP_ZERO_EN
        send(16'd1, 16'h0100, fw, prod);
        check("skip_model_wait", 64'(fw), 64'd2);
        drain(fw, -1, 0, prod);
`endif

        // Random operands with occasional backpressure
        for (int r = 0; r < 8; r++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            send(ra, rb, fw, prod);
            drain(fw, int'($urandom_range(0, NWIN - 1)), int'($urandom_range(0, 3)), prod);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
